// File: rtl/harmonic_scale_gen.sv
// harmonic_scale_gen: per-harmonic amplitude multiplier for the additive oscillator.
// Harmonics are spread over CHANNELS attenuation accumulators by index modulo
// CHANNELS; each request decays the selected accumulator linearly (1 extra cycle)
// or exponentially (2 extra cycles: registered multiply, then subtract).
module harmonic_scale_gen #(
  parameter int unsigned DIV_BIT   = 11,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned HARM_BITS = 7
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset_n,
  input  logic                         i_Restart,
  input  logic                         i_Start,
  input  logic                         i_Mode,
  input  logic [CHANNELS*DIV_BIT-1:0]  i_Scale,
  input  logic [DIV_BIT-1:0]           i_Initial,
  output logic [DIV_BIT-1:0]           o_Mult,
  output logic [HARM_BITS-1:0]         o_Harmonic,
  output logic                         o_Valid,
  output logic                         o_Ready,
  output logic                         o_Exhausted
);

  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PROD_W = 2 * DIV_BIT;
  localparam logic [HARM_BITS-1:0] MAX_HARM = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LIN_CALC = 2'd1,
    EXP_MUL  = 2'd2,
    EXP_SUB  = 2'd3
  } state_t;

  state_t                  state_q, state_nxt;
  logic [DIV_BIT-1:0]      acc [CHANNELS];
  logic [HARM_BITS-1:0]    h_q;
  logic [CH_W-1:0]         ch_q;
  logic [DIV_BIT-1:0]      s_q;
  logic [PROD_W-1:0]       prod_q;

  logic [HARM_BITS-1:0]    h_c;
  logic [CH_W-1:0]         ch_c;
  logic                    accept_c;
  logic                    done_c;
  logic [DIV_BIT-1:0]      acc_new_c;
  logic                    all_zero_c;

  // Index and channel of the harmonic that the next accepted request will produce
  always_comb begin
    h_c  = o_Harmonic + HARM_BITS'(1);
    ch_c = CH_W'(32'(h_c) % CHANNELS);
  end

  // Next-state, accept/complete decode and updated accumulator value
  always_comb begin
    state_nxt  = state_q;
    accept_c   = 1'b0;
    done_c     = 1'b0;
    acc_new_c  = acc[ch_q];
    all_zero_c = 1'b1;
    case (state_q)
      IDLE: begin
        if (i_Start && (o_Harmonic != MAX_HARM)) begin
          accept_c  = 1'b1;
          state_nxt = i_Mode ? EXP_MUL : LIN_CALC;
        end
      end
      LIN_CALC: begin
        done_c    = 1'b1;
        acc_new_c = (acc[ch_q] >= s_q) ? (acc[ch_q] - s_q) : '0;
        state_nxt = IDLE;
      end
      EXP_MUL: begin
        state_nxt = EXP_SUB;
      end
      EXP_SUB: begin
        done_c    = 1'b1;
        acc_new_c = acc[ch_q] - DIV_BIT'(prod_q >> DIV_BIT);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (((CH_W'(c) == ch_q) ? acc_new_c : acc[c]) != '0) all_zero_c = 1'b0;
    end
  end

  // State register; reset and restart both return to IDLE
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n || i_Restart) state_q <= IDLE;
    else                         state_q <= state_nxt;
  end

  // Accumulators, request latches, product register and registered outputs
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      for (int c = 0; c < int'(CHANNELS); c++) acc[c] <= '0;
      h_q         <= '0;
      ch_q        <= '0;
      s_q         <= '0;
      prod_q      <= '0;
      o_Mult      <= '0;
      o_Harmonic  <= '0;
      o_Valid     <= 1'b0;
      o_Ready     <= 1'b1;
      o_Exhausted <= 1'b1;
    end else if (i_Restart) begin
      for (int c = 0; c < int'(CHANNELS); c++) acc[c] <= i_Initial;
      o_Mult      <= i_Initial;
      o_Harmonic  <= '0;
      o_Valid     <= 1'b0;
      o_Ready     <= 1'b1;
      o_Exhausted <= (i_Initial == '0);
    end else begin
      o_Valid <= 1'b0;
      if (accept_c) begin
        h_q     <= h_c;
        ch_q    <= ch_c;
        s_q     <= i_Scale[ch_c*DIV_BIT +: DIV_BIT];
        o_Ready <= 1'b0;
      end
      if (state_q == EXP_MUL) begin
        prod_q <= PROD_W'(acc[ch_q]) * PROD_W'(s_q);
      end
      if (done_c) begin
        acc[ch_q]   <= acc_new_c;
        o_Mult      <= acc_new_c;
        o_Harmonic  <= h_q;
        o_Valid     <= 1'b1;
        o_Ready     <= 1'b1;
        o_Exhausted <= all_zero_c | (h_q == MAX_HARM);
      end
    end
  end

endmodule

// File: tb/tb_harmonic_scale_gen.sv
// Self-checking bench for harmonic_scale_gen: directed table, random model run,
// and hand-written multi-cycle corner cases (index limit, restart abort, reset).
module tb_harmonic_scale_gen;

  logic        clk;
  logic        rst_n;
  logic        restart, start, mode;
  logic [21:0] scale;
  logic [10:0] init;
  logic [10:0] a_mult;
  logic [6:0]  a_harm;
  logic        a_valid, a_ready, a_exh;

  logic        b_restart, b_start;
  logic [10:0] b_mult;
  logic [2:0]  b_harm;
  logic        b_valid, b_ready, b_exh;

  int checks = 0;
  int failures = 0;

  harmonic_scale_gen #(.DIV_BIT(11), .CHANNELS(2), .HARM_BITS(7)) dut_a (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Restart(restart), .i_Start(start),
    .i_Mode(mode), .i_Scale(scale), .i_Initial(init),
    .o_Mult(a_mult), .o_Harmonic(a_harm), .o_Valid(a_valid),
    .o_Ready(a_ready), .o_Exhausted(a_exh));

  harmonic_scale_gen #(.DIV_BIT(11), .CHANNELS(2), .HARM_BITS(3)) dut_b (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Restart(b_restart), .i_Start(b_start),
    .i_Mode(mode), .i_Scale(scale), .i_Initial(init),
    .o_Mult(b_mult), .o_Harmonic(b_harm), .o_Valid(b_valid),
    .o_Ready(b_ready), .o_Exhausted(b_exh));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rs;
    logic [10:0] ini;
    logic [10:0] s0;
    logic [10:0] s1;
    logic        md;
    logic [10:0] em;
    logic [6:0]  eh;
    logic        ex;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Restart with new initial value, then check the reloaded outputs
  task automatic do_restart(input logic [10:0] ini);
    restart = 1'b1;
    init    = ini;
    tick();
    restart = 1'b0;
    chk("restart_mult", 32'(a_mult), 32'(ini));
    chk("restart_harm", 32'(a_harm), 0);
    chk("restart_valid", 32'(a_valid), 0);
    chk("restart_ready", 32'(a_ready), 1);
    chk("restart_exh", 32'(a_exh), (ini == 11'd0) ? 1 : 0);
  endtask

  // Issue one start and wait (bounded) for its o_Valid on DUT A
  task automatic start_req(input logic md, output logic [10:0] m, output logic [6:0] h,
                           output logic x, output int lat, output logic rdy0);
    start = 1'b1;
    mode  = md;
    tick();
    start = 1'b0;
    rdy0  = a_ready;
    lat   = 0;
    while (a_valid !== 1'b1 && lat < 6) begin
      tick();
      lat++;
    end
    m = a_mult;
    h = a_harm;
    x = a_exh;
  endtask

  initial begin
    logic [10:0] m;
    logic [6:0]  h;
    logic        x, rdy0;
    int          lat;
    int          macc [2];
    int          mh, c, s, s0, s1, n;
    logic        md;

    rst_n = 1'b0; restart = 1'b0; start = 1'b0; mode = 1'b0;
    scale = '0; init = '0; b_restart = 1'b0; b_start = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_mult", 32'(a_mult), 0);
    chk("rst_harm", 32'(a_harm), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_ready", 32'(a_ready), 1);
    chk("rst_exh", 32'(a_exh), 1);

    // Directed table: linear, exponential, exhaustion
    tbl[0]  = '{1'b1, 11'd1000, 11'd100,  11'd300,  1'b0, 11'd700,  7'd1, 1'b0};
    tbl[1]  = '{1'b0, 11'd1000, 11'd100,  11'd300,  1'b0, 11'd900,  7'd2, 1'b0};
    tbl[2]  = '{1'b0, 11'd1000, 11'd100,  11'd300,  1'b0, 11'd400,  7'd3, 1'b0};
    tbl[3]  = '{1'b0, 11'd1000, 11'd100,  11'd300,  1'b0, 11'd800,  7'd4, 1'b0};
    tbl[4]  = '{1'b0, 11'd1000, 11'd100,  11'd300,  1'b0, 11'd100,  7'd5, 1'b0};
    tbl[5]  = '{1'b0, 11'd1000, 11'd100,  11'd300,  1'b0, 11'd700,  7'd6, 1'b0};
    tbl[6]  = '{1'b0, 11'd1000, 11'd100,  11'd300,  1'b0, 11'd0,    7'd7, 1'b0};
    tbl[7]  = '{1'b1, 11'd2000, 11'd1024, 11'd1024, 1'b1, 11'd1000, 7'd1, 1'b0};
    tbl[8]  = '{1'b0, 11'd2000, 11'd1024, 11'd1024, 1'b1, 11'd1000, 7'd2, 1'b0};
    tbl[9]  = '{1'b0, 11'd2000, 11'd1024, 11'd1024, 1'b1, 11'd500,  7'd3, 1'b0};
    tbl[10] = '{1'b0, 11'd2000, 11'd1024, 11'd1024, 1'b1, 11'd500,  7'd4, 1'b0};
    tbl[11] = '{1'b1, 11'd100,  11'd2047, 11'd2047, 1'b0, 11'd0,    7'd1, 1'b0};
    tbl[12] = '{1'b0, 11'd100,  11'd2047, 11'd2047, 1'b0, 11'd0,    7'd2, 1'b1};
    tbl[13] = '{1'b0, 11'd100,  11'd2047, 11'd2047, 1'b0, 11'd0,    7'd3, 1'b1};

    for (int i = 0; i < 14; i++) begin
      scale = {tbl[i].s1, tbl[i].s0};
      if (tbl[i].rs) do_restart(tbl[i].ini);
      start_req(tbl[i].md, m, h, x, lat, rdy0);
      chk("tbl_ready_low", 32'(rdy0), 0);
      chk("tbl_latency", 32'(lat), tbl[i].md ? 2 : 1);
      chk("tbl_mult", 32'(m), 32'(tbl[i].em));
      chk("tbl_harm", 32'(h), 32'(tbl[i].eh));
      chk("tbl_exh", 32'(x), 32'(tbl[i].ex));
    end

    // Random sequences against an arithmetic reference model
    for (int r = 0; r < 30; r++) begin
      init = 11'($urandom_range(0, 2047));
      scale = 22'($urandom);
      do_restart(init);
      macc[0] = int'(init);
      macc[1] = int'(init);
      mh = 0;
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) begin
        s0 = $urandom_range(0, 2047);
        s1 = $urandom_range(0, 2047);
        scale = {11'(s1), 11'(s0)};
        md = 1'($urandom_range(0, 1));
        mh++;
        c = mh % 2;
        s = (c == 1) ? s1 : s0;
        if (!md) macc[c] = (macc[c] >= s) ? macc[c] - s : 0;
        else     macc[c] = macc[c] - (macc[c] * s) / 2048;
        start_req(md, m, h, x, lat, rdy0);
        chk("rnd_latency", 32'(lat), md ? 2 : 1);
        chk("rnd_mult", 32'(m), 32'(macc[c]));
        chk("rnd_harm", 32'(h), 32'(mh));
        chk("rnd_exh", 32'(x), ((macc[0] == 0 && macc[1] == 0) || mh == 127) ? 1 : 0);
      end
    end

    // Index limit on the 3-bit-index instance
    scale = {11'd10, 11'd10};
    mode = 1'b0;
    init = 11'd1000;
    b_restart = 1'b1;
    tick();
    b_restart = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      tick();
      chk("lim_valid", 32'(b_valid), 1);
      chk("lim_harm", 32'(b_harm), 32'(k));
    end
    chk("lim_exh", 32'(b_exh), 1);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("lim_ignored_ready", 32'(b_ready), 1);
    chk("lim_ignored_valid", 32'(b_valid), 0);
    tick();
    chk("lim_ignored_valid2", 32'(b_valid), 0);
    chk("lim_ignored_harm", 32'(b_harm), 7);

    // Restart one cycle into an exponential calculation aborts it
    scale = {11'd1024, 11'd1024};
    do_restart(11'd2000);
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0;
    restart = 1'b1; init = 11'd555;
    tick();
    restart = 1'b0;
    chk("abort_valid", 32'(a_valid), 0);
    chk("abort_mult", 32'(a_mult), 555);
    chk("abort_harm", 32'(a_harm), 0);
    chk("abort_ready", 32'(a_ready), 1);
    tick();
    chk("abort_no_late_valid", 32'(a_valid), 0);

    // Start and restart on the same edge: start dropped
    start = 1'b1; restart = 1'b1; init = 11'd300;
    tick();
    start = 1'b0; restart = 1'b0;
    chk("same_edge_ready", 32'(a_ready), 1);
    chk("same_edge_harm", 32'(a_harm), 0);
    tick();
    chk("same_edge_valid", 32'(a_valid), 0);

    // Start while busy is ignored
    start = 1'b1; mode = 1'b1;
    tick();
    chk("busy_ready", 32'(a_ready), 0);
    tick();
    start = 1'b0;
    chk("busy_valid_early", 32'(a_valid), 0);
    tick();
    chk("busy_valid", 32'(a_valid), 1);
    chk("busy_mult", 32'(a_mult), 150);
    chk("busy_harm", 32'(a_harm), 1);
    tick();
    chk("busy_valid_once", 32'(a_valid), 0);
    chk("busy_ready_after", 32'(a_ready), 1);
    chk("busy_harm_hold", 32'(a_harm), 1);

    // Reset mid-calculation with restart also asserted
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0;
    rst_n = 1'b0; restart = 1'b1; init = 11'd777;
    tick();
    rst_n = 1'b1; restart = 1'b0;
    chk("midrst_mult", 32'(a_mult), 0);
    chk("midrst_harm", 32'(a_harm), 0);
    chk("midrst_valid", 32'(a_valid), 0);
    chk("midrst_ready", 32'(a_ready), 1);
    chk("midrst_exh", 32'(a_exh), 1);
    tick();
    chk("midrst_no_valid", 32'(a_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/harmonic_scale_gen.md
# harmonic_scale_gen

Generates the per-harmonic amplitude multiplier for the additive oscillator, one value per request. It splits harmonics across CHANNELS independent attenuation accumulators, using harmonic index modulo CHANNELS, so odd and even harmonics can roll off differently. Each accumulator decays either linearly or exponentially. It sits between the harmonic sequencer, which drives i_Start and i_Restart, and the sample multiplier, which consumes o_Mult and o_Valid.

## Interface
- DIV_BIT, 11, width of scale, initial and multiplier values.
- CHANNELS, 2, number of independent accumulators (≥1).
- HARM_BITS, 7, width of harmonic index; MAX_HARM = 2^HARM_BITS − 1.
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- i_Restart  in  1  start of new sample: reload accumulators, harmonic index to 0.
- i_Start  in  1  request next harmonic's multiplier.
- i_Mode  in  1  0 = linear decay, 1 = exponential decay.
- i_Scale  in  CHANNELS*DIV_BIT  per-channel decay amount; channel c in bits [c*DIV_BIT +: DIV_BIT].
- i_Initial  in  DIV_BIT  fundamental (harmonic 0) multiplier.
- o_Mult  out  DIV_BIT  current multiplier.
- o_Harmonic  out  HARM_BITS  harmonic index of o_Mult.
- o_Valid  out  1  one-cycle pulse: new o_Mult/o_Harmonic.
- o_Ready  out  1  idle, i_Start will be accepted.
- o_Exhausted  out  1  all accumulators zero or o_Harmonic = MAX_HARM.

## Operation
- Priority per edge: i_Reset_n low > i_Restart > i_Start.
- Reset values:
  - acc[*] = 0, o_Mult = 0, o_Harmonic = 0.
  - o_Valid = 0, o_Ready = 1, o_Exhausted = 1.
  - State IDLE.
- i_Restart:
  - acc[*] = i_Initial, o_Mult = i_Initial, o_Harmonic = 0.
  - o_Valid = 0, o_Ready = 1, state IDLE.
  - o_Exhausted = (i_Initial == 0).
  - Aborts any in-flight calculation; no o_Valid is issued for it.
- Accept: i_Start & o_Ready & (o_Harmonic ≠ MAX_HARM).
  - Latch h = o_Harmonic + 1, ch = h mod CHANNELS, s = i_Scale[ch], and i_Mode.
  - i_Start when not accepted is dropped; there is no queueing.
- Linear update: acc[ch] = (acc[ch] ≥ s) ? acc[ch] − s : 0.
- Exponential update: p = acc[ch] * s (2*DIV_BIT bits, registered); acc[ch] = acc[ch] − p[2*DIV_BIT−1:DIV_BIT].
  - The result never underflows because s < 2^DIV_BIT.
- On completion, in the same edge:
  - o_Mult = new acc[ch], o_Harmonic = h.
  - o_Valid = 1 for one cycle, o_Ready = 1.
  - o_Exhausted = (all acc zero after update) | (h == MAX_HARM).
- States:
  - IDLE: on accept go to LIN_CALC (mode 0) or EXP_MUL (mode 1).
  - LIN_CALC: to IDLE.
  - EXP_MUL: to EXP_SUB.
  - EXP_SUB: to IDLE.
- When all accumulators are zero, requests are still accepted and produce o_Mult = 0 with an incrementing index, which keeps the sequencer aligned.
- At o_Harmonic = MAX_HARM, i_Start is ignored: no o_Valid, and o_Ready stays 1.

## Timing
- Accept at edge E: o_Ready = 0 after E.
- Linear: o_Valid and o_Mult after E+1, o_Ready = 1 after E+1. Issue interval is 2 cycles.
- Exponential: product registered at E+1; o_Valid and o_Ready after E+2. Issue interval is 3 cycles.
- o_Valid is high exactly one cycle and never during IDLE without a completion.
- o_Mult and o_Harmonic hold between completions.
- i_Restart at any edge takes effect at that edge. o_Valid is forced low that cycle even if a completion was due.

## Test plan
- Linear: DIV_BIT=11, CHANNELS=2; restart with i_Initial=1000, scale ch0=100, ch1=300; 7 starts.
  - Required o_Mult/o_Harmonic: 700/1, 900/2, 400/3, 800/4, 100/5, 700/6, 0/7.
  - Each o_Valid occurs 1 edge after accept.
- Exponential: i_Initial=2000, both scales=1024; 4 starts.
  - Required o_Mult: 1000, 1000, 500, 500.
  - o_Valid 2 edges after accept; o_Ready low for 2 cycles.
- Exhaustion: i_Initial=100, scales=2047, linear.
  - Harmonics 1 and 2 both give 0; o_Exhausted rises with the harmonic-2 o_Valid.
  - A third start gives o_Mult=0, o_Harmonic=3.
- Index limit: HARM_BITS=3.
  - After 7 completions, o_Harmonic=7 and o_Exhausted=1.
  - An 8th i_Start gives no o_Valid; o_Ready stays 1.
- Restart abort:
  - Restart at E+1 of an exponential calculation → no o_Valid, o_Mult=i_Initial, o_Harmonic=0.
  - i_Start and i_Restart on the same edge → start dropped, o_Ready=1.
  - i_Start while o_Ready=0 → ignored.
- Reset: i_Reset_n low mid-calculation, with i_Restart also high.
  - Next cycle: o_Mult=0, o_Harmonic=0, o_Valid=0, o_Ready=1, o_Exhausted=1.
